// File: rtl/binary_search_control.sv
// Control FSM for a binary search over a sync-RAM-backed sorted array.
// Commands an external pointer datapath (front/mid/last) and reports hit/miss, address and probe count.
module binary_search_control #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] target,
  input  logic [DATA_W-1:0] ram_data,
  input  logic [ADDR_W-1:0] front,
  input  logic [ADDR_W-1:0] mid,
  input  logic [ADDR_W-1:0] last,
  output logic              loads,
  output logic              lt,
  output logic              gt,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] result_addr,
  output logic [2:0]        probes
);

  typedef enum logic [2:0] {IDLE, WAIT1, WAIT2, CMP, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic              found_q, found_d;
  logic [ADDR_W-1:0] result_addr_q, result_addr_d;
  logic [2:0]        probes_q, probes_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      target_q      <= '0;
      found_q       <= 1'b0;
      result_addr_q <= '0;
      probes_q      <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      found_q       <= found_d;
      result_addr_q <= result_addr_d;
      probes_q      <= probes_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    found_d       = found_q;
    result_addr_d = result_addr_q;
    probes_d      = probes_q;
    loads         = 1'b0;
    lt            = 1'b0;
    gt            = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      IDLE: begin
        loads = 1'b1;
        if (start) begin
          target_d = target;
          found_d  = 1'b0;
          probes_d = '0;
          state_d  = WAIT1;
        end
      end
      // Two wait cycles: mid recompute lag, then RAM read latency.
      WAIT1: state_d = WAIT2;
      WAIT2: state_d = CMP;
      CMP: begin
        probes_d = probes_q + 3'd1;
        if (ram_data == target_q) begin
          found_d       = 1'b1;
          result_addr_d = mid;
          state_d       = DONE;
        end else if (ram_data > target_q) begin
          // Edge checks stop mid-1 underflow / mid+1 wrap at the array ends.
          if (mid == front) state_d = DONE;
          else begin
            lt      = 1'b1;
            state_d = WAIT1;
          end
        end else begin
          if (mid == last) state_d = DONE;
          else begin
            gt      = 1'b1;
            state_d = WAIT1;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign found       = found_q;
  assign result_addr = result_addr_q;
  assign probes      = probes_q;

endmodule

// File: doc/binary_search_control.md
BINARY_SEARCH_CONTROL -- requirements
Module: binary_search_control

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of target and RAM data.
REQ-002 Parameter ADDR_W, default 5, SHALL set the width of front/mid/last/result_addr (32-entry array).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be synchronous and active-high.
REQ-005 start  in  1  search request, level-sensitive.
REQ-006 target  in  DATA_W  value to find; SHALL be latched when start is accepted.
REQ-007 ram_data  in  DATA_W  sync-RAM read data; SHALL be valid one cycle after the address (mid) is presented.
REQ-008 front, mid, last  in  ADDR_W each  current pointers from the search datapath.
REQ-009 loads, lt, gt  out  1 each  datapath commands: init pointers / move last below mid / move front above mid.
REQ-010 done  out  1  search complete.
REQ-011 found  out  1  target present; valid while done=1.
REQ-012 result_addr  out  ADDR_W  matching address; valid while found=1.
REQ-013 probes  out  3  number of compares in the current or last search.

Function
REQ-014 FSM states SHALL be IDLE, WAIT1, WAIT2, CMP and DONE; loads, lt, gt and done SHALL be Moore/compare decodes, and found, result_addr and probes SHALL be registers.
REQ-015 IDLE: loads=1; when start=1 the block SHALL latch target, clear found and probes, and go to WAIT1; otherwise it stays in IDLE.
REQ-016 WAIT1 SHALL go to WAIT2, and WAIT2 SHALL go to CMP, with loads=lt=gt=0; this covers the one-cycle mid recompute lag plus the one-cycle RAM latency.
REQ-017 CMP SHALL increment probes and compare ram_data against the latched target as unsigned values.
REQ-018 CMP, ram_data==target: the block SHALL set found=1 and result_addr=mid, and go to DONE.
REQ-019 CMP, ram_data>target: if mid==front, go to DONE with found=0; else drive lt=1 for this cycle only and go to WAIT1.
REQ-020 CMP, ram_data<target: if mid==last, go to DONE with found=0; else drive gt=1 for this cycle only and go to WAIT1.
REQ-021 lt and gt SHALL never both be 1, and SHALL be 0 outside CMP.
REQ-022 The mid==front and mid==last checks SHALL prevent a mid-1 underflow at address 0 and a mid+1 wrap at address 31.
REQ-023 DONE: done=1 and loads=0; found, result_addr and probes SHALL hold; the block SHALL stay in DONE while start=1 and return to IDLE the cycle after start=0.
REQ-024 result_addr SHALL be a register, because the datapath keeps recomputing mid while in DONE.
REQ-025 Timing: with start accepted at edge E0, probe k's CMP SHALL occur in cycle 3k after E0, and done SHALL first be 1 in cycle 3n+1, where n is the final probe count.
REQ-026 probes SHALL never exceed 6 for a 32-entry array.
REQ-027 A start rising while in WAIT1/WAIT2/CMP/DONE SHALL be ignored, and a change on target after acceptance SHALL have no effect.

Reset
REQ-028 When reset=1 at a clock edge, state SHALL become IDLE from any state, including mid-search.
REQ-029 Reset SHALL clear found, result_addr, probes and the latched target to 0.
REQ-030 Outputs after reset SHALL be loads=1, lt=gt=done=0.
REQ-031 Reset SHALL take priority over start in the same cycle.

Verification (bench: this block + the search datapath + a 32x8 sync RAM with ram[i]=2*i, RAM address = mid)
REQ-032 target=30: start -> first probe at mid=15; found=1, result_addr=15, probes=1, done first high in cycle 4.
REQ-033 target=0: probes at mid 15,7,3,1,0 with lt each time -> found=1, result_addr=0, probes=5, no underflow.
REQ-034 target=62: probes at mid 15,23,27,29,30,31 with gt each time -> found=1, result_addr=31, probes=6, done in cycle 19.
REQ-035 target=31 (absent): probes at mid 15,23,19,17,16; at mid=16 (ram_data=32>31) mid==front -> done=1, found=0, probes=5, lt never pulsed in the final CMP.
REQ-036 Hold start=1 for 10 cycles after done: done, found and result_addr SHALL stay stable while mid moves; drop start -> the next cycle shows IDLE, done=0, loads=1.
REQ-037 Assert reset during WAIT2 of probe 2 -> the next cycle shows IDLE, done=found=0, probes=0, loads=1; a fresh start with target=30 SHALL then complete per REQ-032.
